// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the wait-stated memory responder.
//   - FSM state encoding (IDLE/WAIT/RESP)
//   - bytes per word and request opcode encoding
//   - req_t: the request captured at accept time
package mem_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int WORD_BYTES = 4;

  // op = {memread, memwrite}
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  op;
  } req_t;

endpackage

// File: rtl/mem_array.sv
// mem_array: DEPTH x 32-bit word storage.
// Ports:
//   clk    in   rising-edge clock for writes
//   we     in   write enable
//   waddr  in   word index written when we=1
//   wdata  in   word stored
//   raddr  in   word index read
//   rdata  out  combinational read of word raddr
// Contents are deliberately never reset.
module mem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory target with WAIT_CYCLES wait states.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   address    in   byte address (bits [1:0] must be 0)
//   writeData  in   store data, sampled at accept
//   memread    in   read request level
//   memwrite   in   write request level
//   readData   out  registered read result, held until the next good read
//   ready      out  one-cycle completion pulse
//   err        out  error flag, meaningful only while ready=1
//
// Handshake: a request is accepted on a rising edge in IDLE whenever
// memread|memwrite is high; address/writeData/op are captured then and the
// inputs are ignored until the response. ready pulses exactly once,
// WAIT_CYCLES+1 cycles after the accept edge; the requester must drop its
// request in the cycle after ready, otherwise a level still high in IDLE
// is accepted as a new request.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  input  logic        memread,
  input  logic        memwrite,
  output logic [31:0] readData,
  output logic        ready,
  output logic        err
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  // 33 bits so that the bound stays representable for the largest depths.
  localparam logic [32:0] LIMIT    = 33'(WORD_BYTES) * 33'(DEPTH);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;

  req_t        live;
  req_t        acc;
  logic        go_resp;
  logic        acc_err;
  logic        arr_we;
  logic [31:0] arr_rdata;

  always_comb begin
    live    = '{addr: address, wdata: writeData, op: {memread, memwrite}};
    // The access always happens on the edge entering RESP. With zero wait
    // states that edge is the accept edge itself, so the live inputs are the
    // request; otherwise the latched copy is.
    acc     = (state_q == IDLE) ? live : req_q;

    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    go_resp = 1'b0;

    case (state_q)
      IDLE: begin
        if (memread | memwrite) begin
          req_d = live;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            go_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_err = (acc.addr[1:0] != 2'b00) ||
              ({1'b0, acc.addr} >= LIMIT) ||
              (acc.op == (OP_READ | OP_WRITE));

    ready_d = go_resp;
    err_d   = go_resp & acc_err;

    rdata_d = rdata_q;
    if (go_resp && !acc_err && acc.op == OP_READ) begin
      rdata_d = arr_rdata;
    end

    // Gated by rst_n so a live write request can never reach the array
    // while reset is held.
    arr_we = rst_n & go_resp & ~acc_err & (acc.op == OP_WRITE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      req_q   <= '0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (acc.addr[AW+1:2]),
    .wdata (acc.wdata),
    .raddr (acc.addr[AW+1:2]),
    .rdata (arr_rdata)
  );

  assign readData = rdata_q;
  assign ready    = ready_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: drives two responders (WAIT_CYCLES=2 as index 0,
// WAIT_CYCLES=0 as index 1) and compares them with a word-array model.
module tb_mem_responder;

  localparam int DEPTH = 256;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr_i  [2];
  logic [31:0] wdata_i [2];
  logic        rd_i    [2];
  logic        wr_i    [2];
  logic [31:0] rdata_o [2];
  logic        rdy_o   [2];
  logic        err_o   [2];

  int n_checks;
  int n_pass;

  // reference model: per-DUT word contents and expected readData
  logic [31:0] model_mem [2][DEPTH];
  logic [31:0] model_rd  [2];

  mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) dut_w2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .address   (addr_i[0]),
    .writeData (wdata_i[0]),
    .memread   (rd_i[0]),
    .memwrite  (wr_i[0]),
    .readData  (rdata_o[0]),
    .ready     (rdy_o[0]),
    .err       (err_o[0])
  );

  mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_w0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .address   (addr_i[1]),
    .writeData (wdata_i[1]),
    .memread   (rd_i[1]),
    .memwrite  (wr_i[1]),
    .readData  (rdata_o[1]),
    .ready     (rdy_o[1]),
    .err       (err_o[1])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic drop(input int d);
    addr_i[d]  = 32'd0;
    wdata_i[d] = 32'd0;
    rd_i[d]    = 1'b0;
    wr_i[d]    = 1'b0;
  endtask

  // One complete transaction. With scramble set, the request inputs are
  // changed to a different write right after accept and held until ready.
  task automatic do_req(input int d, input logic [31:0] a, input logic [31:0] wd,
                        input logic r, input logic w, input bit scramble, input string tag);
    logic exp_err;
    int   idx;
    int   lat;
    @(negedge clk);
    addr_i[d]  = a;
    wdata_i[d] = wd;
    rd_i[d]    = r;
    wr_i[d]    = w;

    exp_err = (a % 4 != 0) || (a >= 4 * DEPTH) || (r && w);
    idx     = int'(a / 4);
    if (!exp_err && w) model_mem[d][idx] = wd;
    if (!exp_err && r) model_rd[d] = model_mem[d][idx];

    lat = lat_of(d);
    @(posedge clk);
    #1;
    if (scramble) begin
      addr_i[d]  = 32'h20;
      wdata_i[d] = $urandom;
      rd_i[d]    = 1'($urandom_range(0, 1));
      wr_i[d]    = 1'b1;
    end else begin
      drop(d);
    end
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      check({tag, "_rdy"}, 32'(rdy_o[d]), 32'(k == lat + 1));
      if (k == lat + 1) begin
        check({tag, "_err"}, 32'(err_o[d]), 32'(exp_err));
        check({tag, "_rdata"}, rdata_o[d], model_rd[d]);
      end
    end
    drop(d);
  endtask

  task automatic rand_req(input int d);
    logic [31:0] a;
    logic [1:0]  op;
    int          sel;
    sel = $urandom_range(0, 9);
    a   = 32'($urandom_range(0, 15)) * 4;
    if (sel == 0) a = a + 32'($urandom_range(1, 3));
    else if (sel == 1) a = 32'h400 + 32'($urandom_range(0, 1000)) * 4;
    op = 2'($urandom_range(1, 3));
    do_req(d, a, $urandom, op[1], op[0], bit'($urandom_range(0, 1)), "rand");
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    for (int d = 0; d < 2; d++) begin
      drop(d);
      model_rd[d] = 32'd0;
    end

    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_rdy", 32'(rdy_o[d]), 32'd0);
      check("reset_err", 32'(err_o[d]), 32'd0);
      check("reset_rdata", rdata_o[d], 32'd0);
    end
    rst_n = 1'b1;

    // give the words used below known contents
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++)
        do_req(d, 32'(i * 4), $urandom, 1'b0, 1'b1, 1'b0, "init");

    // WAIT_CYCLES=2: write then read, errors, input change after accept
    do_req(0, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, "w2_write");
    do_req(0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0, "w2_read");
    do_req(0, 32'h12, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, "misalign");
    do_req(0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0, "after_misalign");
    do_req(0, 32'h400, 32'h0, 1'b1, 1'b0, 1'b0, "out_of_range");
    do_req(0, 32'h20, 32'h55AA55AA, 1'b1, 1'b1, 1'b0, "conflict");
    do_req(0, 32'h20, 32'h0, 1'b1, 1'b0, 1'b0, "after_conflict");
    do_req(0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b1, "late_change");
    do_req(0, 32'h20, 32'h0, 1'b1, 1'b0, 1'b0, "no_late_write");

    // WAIT_CYCLES=0: write then read, then a held request
    do_req(1, 32'h0, 32'h12345678, 1'b0, 1'b1, 1'b0, "w0_write");
    do_req(1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, "w0_read");
    @(negedge clk);
    addr_i[1] = 32'h4;
    rd_i[1]   = 1'b1;
    model_rd[1] = model_mem[1][1];
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("b2b_rdy", 32'(rdy_o[1]), 32'(k % 2));
      if (k % 2 == 1) check("b2b_rdata", rdata_o[1], model_rd[1]);
    end
    drop(1);

    // reset during WAIT aborts a write to 0x30
    @(negedge clk);
    addr_i[0]  = 32'h30;
    wdata_i[0] = 32'hA5A5A5A5;
    wr_i[0]    = 1'b1;
    @(posedge clk);
    #1;
    drop(0);
    @(negedge clk);
    rst_n = 1'b0;
    model_rd[0] = 32'd0;
    model_rd[1] = 32'd0;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("rst_mid_rdy", 32'(rdy_o[0]), 32'd0);
      check("rst_mid_err", 32'(err_o[0]), 32'd0);
      check("rst_mid_rdata", rdata_o[0], 32'd0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rst_no_rdy", 32'(rdy_o[0]), 32'd0);
    end
    do_req(0, 32'h30, 32'h0, 1'b1, 1'b0, 1'b0, "rst_read_back");

    // randomized traffic
    for (int i = 0; i < 30; i++) begin
      rand_req(0);
      rand_req(1);
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Word-addressed memory target serving the multicycle processor's memread/memwrite requests, replacing the zero-latency memory model with a wait-stated responder.
- It latches a request, inserts WAIT_CYCLES wait states, then completes the read or write and pulses ready.
- It flags misaligned, out-of-range and conflicting requests.
- It sits between the processor datapath (address mux, B register, MDR) and the backing storage array.

Parameters:
- DEPTH, 256, number of 32-bit words stored; must be a power of two, at least 2.
- WAIT_CYCLES, 2, wait states inserted between accept and completion; 0 to 15 allowed.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- address  input  32  byte address; bits [1:0] must be 0.
- writeData  input  32  store data, sampled at accept.
- memread  input  1  read request level.
- memwrite  input  1  write request level.
- readData  output  32  registered read result.
- ready  output  1  one-cycle completion pulse.
- err  output  1  error flag, valid only while ready=1.

Behaviour:
- Reset is asynchronous and active-low.
  - Outputs: readData=0, ready=0, err=0.
  - Internals: state=IDLE, wait counter=0.
  - Storage contents are not cleared.
- States:
  - IDLE: wait for a request.
  - WAIT: count wait states.
  - RESP: complete the access.
- IDLE: a request is accepted on a rising edge when memread|memwrite=1.
  - At accept, latch address, writeData and op = {memread, memwrite}.
  - Go to WAIT with the counter loaded to WAIT_CYCLES-1 if WAIT_CYCLES>0, else go directly to RESP.
- WAIT: decrement the counter each edge; when the counter reaches 0, go to RESP on the next edge.
- Latency: ready is high in exactly the cycle following accept edge + WAIT_CYCLES edges.
  - WAIT_CYCLES=0: ready is high in the cycle right after the accept edge.
  - WAIT_CYCLES=2: ready is high in the 3rd cycle after accept.
- Access happens at the edge entering RESP.
  - Valid write: store the latched data at word index address[log2(DEPTH)+1:2].
  - Valid read: load readData from the array.
- RESP: ready=1 for one cycle, then return to IDLE unconditionally.
  - Requester must drop its request in the cycle after ready. A request still high in IDLE is treated as a new request.
- readData holds its value until the next successful read completes. Writes and errored accesses leave it unchanged.
- Error cases: ready still pulses with the normal latency, err=1, no array write, readData unchanged. Errors are:
  - misaligned: latched address[1:0] != 0;
  - out of range: latched address >= 4*DEPTH;
  - conflict: memread and memwrite both 1 at accept.
- Request inputs are ignored in WAIT and RESP.
  - Changes to address, writeData, memread or memwrite after accept have no effect.
- Reset asserted in WAIT or RESP before the array-write edge aborts the access. The write is not performed and ready stays 0.
- Read-after-write to the same address returns the newly written data. There is no forwarding hazard because accesses are serialised.

Decomposition:
- Shared package mem_pkg:
  - state encoding: IDLE=2'd0, WAIT=2'd1, RESP=2'd2;
  - WORD_BYTES=4;
  - op encoding: OP_READ=2'b10, OP_WRITE=2'b01.
- Sub-module mem_array: DEPTH x 32 storage.
  - Synchronous write (we, waddr, wdata).
  - Combinational read (raddr, rdata).
  - mem_responder owns the FSM, counter, latches and error checks.

Test Plan:
- Write then read, WAIT_CYCLES=2: write 0xDEADBEEF to address 0x10, ready in the 3rd cycle with err=0. Then read address 0x10: ready in the 3rd cycle, readData=0xDEADBEEF.
- Zero wait, WAIT_CYCLES=0: read address 0x0 after writing 0x12345678; ready in the cycle right after accept, readData=0x12345678. Back-to-back requests alternate ready, IDLE, ready.
- Misaligned: write 0xFFFFFFFF to address 0x12 -> ready with err=1. A following read of address 0x10 returns its old value, and readData is unchanged at the error pulse.
- Out of range and conflict, DEPTH=256:
  - read address 0x400 -> err=1, readData unchanged;
  - memread=memwrite=1 at address 0x20 -> err=1, word 0x20 unmodified.
- Reset mid-wait: accept a write of 0xA5A5A5A5 to address 0x30, assert rst_n=0 during WAIT. Check that ready never pulses and all outputs are 0. After release, reading address 0x30 returns the prior contents.
- Input change after accept: start a read of address 0x10, then switch address to 0x20 and memwrite=1 in WAIT. The response is a read of address 0x10 and no write occurs.
